// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle for alu_arbiter.
// slave = arbiter view, master = requesters / ALU / consumer view.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_f;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_f;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_f;
    logic [31:0] alu_s;
    logic        alu_z;
    logic        alu_c;
    logic        alu_o;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_s;
    logic        resp_z;
    logic        resp_c;
    logic        resp_o;
    logic        resp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_f,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_f,
        output req1_ready,
        output alu_a, alu_b, alu_f,
        input  alu_s, alu_z, alu_c, alu_o,
        output resp_valid, resp_id, resp_s, resp_z, resp_c, resp_o, resp_err,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_f,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_f,
        input  req1_ready,
        input  alu_a, alu_b, alu_f,
        output alu_s, alu_z, alu_c, alu_o,
        input  resp_valid, resp_id, resp_s, resp_z, resp_c, resp_o, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters (optional ALU_ILLEGAL_OP_EN).
// Latency: resp_valid SETTLE_CYCLES edges after accept; 1 edge for illegal codes when enabled.
// Backpressure: response held while resp_ready=0; no new accept until the response is taken.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // SETTLE_CYCLES is expected in 1..15 so the load value fits the 4-bit counter.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_id;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_f;

    logic        r_resp_valid;
    logic        r_resp_id;
    logic [31:0] r_resp_s;
    logic        r_resp_z;
    logic        r_resp_c;
    logic        r_resp_o;

    logic        w_any_vld;
    logic        w_grant;
    logic        w_rdy0;
    logic        w_rdy1;
    logic        w_accept;
    logic        w_capture;
    logic        w_resp_hs;
    logic        w_skip;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [3:0]  w_sel_f;

    // Tie-break favours the requester that did not win last time.
    assign w_any_vld = bus.req0_valid | bus.req1_valid;
    assign w_grant   = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

    assign w_sel_a = w_grant ? bus.req1_a : bus.req0_a;
    assign w_sel_b = w_grant ? bus.req1_b : bus.req0_b;
    assign w_sel_f = w_grant ? bus.req1_f : bus.req0_f;

`ifdef ALU_ILLEGAL_OP_EN
    logic r_illegal;
    logic r_resp_err;

    // Unit selects 00 and 11 map to no functional unit.
    assign w_skip       = (w_sel_f[3:2] == 2'b00) || (w_sel_f[3:2] == 2'b11);
    assign bus.resp_err = r_resp_err;
`else
    assign w_skip       = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)       w_state_nxt = SETTLE;
            SETTLE:  if (r_cnt == 4'd0)  w_state_nxt = DONE;
            DONE:    if (bus.resp_ready) w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        w_rdy0    = 1'b0;
        w_rdy1    = 1'b0;
        w_capture = 1'b0;
        w_resp_hs = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_vld) begin
                    w_rdy0 = ~w_grant;
                    w_rdy1 = w_grant;
                end
            end
            SETTLE:  w_capture = (r_cnt == 4'd0);
            DONE:    w_resp_hs = bus.resp_ready;
            default: ;
        endcase
    end

    assign w_accept = w_rdy0 | w_rdy1;

    // Illegal codes pass through SETTLE with a zero count, so the response lands one edge after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_f      <= '0;
`ifdef ALU_ILLEGAL_OP_EN
            r_illegal    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= w_skip ? 4'd0 : CNT_INIT;
`ifdef ALU_ILLEGAL_OP_EN
                r_illegal    <= w_skip;
`endif
                if (!w_skip) begin
                    r_alu_a <= w_sel_a;
                    r_alu_b <= w_sel_b;
                    r_alu_f <= w_sel_f;
                end
            end else if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response register: result and flags stay put after the handshake, only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_s     <= '0;
            r_resp_z     <= 1'b0;
            r_resp_c     <= 1'b0;
            r_resp_o     <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            if (w_capture) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_resp_s     <= bus.alu_s;
                r_resp_z     <= bus.alu_z;
                r_resp_c     <= bus.alu_c;
                r_resp_o     <= bus.alu_o;
`ifdef ALU_ILLEGAL_OP_EN
                r_resp_err   <= r_illegal;
                if (r_illegal) begin
                    r_resp_s <= '0;
                    r_resp_z <= 1'b0;
                    r_resp_c <= 1'b0;
                    r_resp_o <= 1'b0;
                end
`endif
            end else if (w_resp_hs) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;

    assign bus.alu_a = r_alu_a;
    assign bus.alu_b = r_alu_b;
    assign bus.alu_f = r_alu_f;

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_s     = r_resp_s;
    assign bus.resp_z     = r_resp_z;
    assign bus.resp_c     = r_resp_c;
    assign bus.resp_o     = r_resp_o;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters: req0 and req1.
- Accepts one operation at a time, using round-robin arbitration and a valid/ready handshake.
- Drives registered operands and function code to the ALU, then waits SETTLE_CYCLES clocks for the ALU's combinational delay (up to 17.5 ns).
- Captures result and flags into a tagged response register held until the consumer accepts it.

Parameters:
SETTLE_CYCLES, 2, clocks between driving ALU inputs and sampling ALU outputs; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  operand A, requester 0
req0_b  in  32  operand B, requester 0
req0_f  in  4  function code, requester 0 ([3:2] unit select, [1:0] op)
req1_valid, req1_ready, req1_a, req1_b, req1_f  same as above, requester 1
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_f  out  4  registered function code to ALU
alu_s  in  32  ALU result
alu_z  in  1  ALU zero flag
alu_c  in  1  ALU carry flag
alu_o  in  1  ALU overflow flag
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_id  out  1  requester that issued the operation
resp_s  out  32  captured result
resp_z, resp_c, resp_o  out  1 each  captured flags
resp_err  out  1  illegal function code (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, counter=0, last_grant=1 (req0 wins first tie).
  - alu_a/alu_b/alu_f=0.
  - resp_* all 0, req*_ready=0.
  - An in-flight operation is discarded; no response is ever produced for it.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - reqN_ready is combinational: (state==IDLE) && grant==N.
  - grant=the only valid requester; if both valid, the one not equal to last_grant.
  - Only one ready high per cycle.
  - On accept edge: latch a/b/f into alu_*, latch id, last_grant=id, counter=SETTLE_CYCLES-1, go SETTLE.
- SETTLE:
  - alu_* held stable; counter decrements each clock.
  - On the edge where counter==0: capture alu_s/z/c/o into resp_*, set resp_valid=1, go DONE.
  - resp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
  - SETTLE_CYCLES=1: capture on the first edge after accept.
- DONE:
  - resp_* held stable while resp_ready=0 (no overwrite, no new accept).
  - On the edge with resp_ready=1: resp_valid=0, go IDLE. resp_s/flags keep their value; only resp_valid changes.
  - No same-cycle bypass: next accept is earliest one cycle after the response handshake.
  - Minimum period per operation is SETTLE_CYCLES+2 clocks.
- Requesters must hold valid and operands until ready. Deasserting valid without ready is allowed and the request is dropped.
- A requester with valid continuously high is served at least every second operation.
- alu_* keep the last operation's values in IDLE; they are not cleared.

Optional Feature:
Macro: ALU_ILLEGAL_OP_EN
- Defined: an accepted request with f[3:2]==2'b00 or 2'b11 (unit select maps to no functional unit) skips SETTLE.
  - Next edge: resp_valid=1, resp_err=1, resp_s=0, resp_z=resp_c=resp_o=0.
  - alu_a/alu_b/alu_f are not updated.
  - Legal codes give resp_err=0.
- Undefined: every code is forwarded to the ALU and follows the normal SETTLE path; resp_err is tied to 0.

Test Plan:
(Bench ALU model: fixed 15 ns delay; f=4'b0100 returns A+B, f=4'b1000 returns A&B.)
1. Single op: req0 a=32'h0000_0005, b=32'h0000_0003, f=4'b0100, SETTLE_CYCLES=2, resp_ready=1 -> resp_valid rises 2 edges after accept, resp_s=32'h8, resp_id=0, resp_z=0.
2. Zero and carry: req1 a=32'hFFFF_FFFF, b=32'h1, f=4'b0100 -> resp_s=0, resp_z=1, resp_c=1, resp_id=1.
3. Round-robin: both valid continuously for 4 ops, resp_ready=1 -> grant order 0,1,0,1; each ready a single-cycle pulse.
4. Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* stable, req*_ready=0 throughout; resp_ready=1 -> IDLE, next accept exactly one cycle later.
5. Reset mid-SETTLE: assert rst_n=0 one cycle after accept -> all outputs 0 immediately (async); after release, no response for the dropped op; a fresh req0 is served.
6. ALU_ILLEGAL_OP_EN defined, req0 f=4'b1100 -> resp_valid on next edge, resp_err=1, resp_s=0, alu_f unchanged. Undefined -> normal latency, resp_err=0.
